// File: rtl/vga_timing_gen.sv
// VGA timing generator with configurable porches/polarities, four test patterns,
// pixel coordinates, data enable and a frame-start strobe; all outputs registered.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 29,
    parameter int unsigned HSYNC_POL = 0,
    parameter int unsigned VSYNC_POL = 0,
    parameter int unsigned RW        = 3,
    parameter int unsigned GW        = 3,
    parameter int unsigned BW        = 2,
    parameter int unsigned CNT_W     = 10
) (
    input  logic             dclk,
    input  logic             clr,
    input  logic             en,
    input  logic [1:0]       mode,
    output logic             hsync,
    output logic             vsync,
    output logic [RW-1:0]    red,
    output logic [GW-1:0]    green,
    output logic [BW-1:0]    blue,
    output logic             de,
    output logic [CNT_W-1:0] px,
    output logic [CNT_W-1:0] py,
    output logic             frame_start
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] H_ACT_BEG  = CNT_W'(H_SYNC + H_BP);
    localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_BEG  = CNT_W'(V_SYNC + V_BP);
    localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [CNT_W-1:0] H_ACT_LAST = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_ACT_LAST = CNT_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] BAR_W      = CNT_W'(H_ACTIVE / 8);
    localparam logic             HS_ON      = (HSYNC_POL != 0);
    localparam logic             VS_ON      = (VSYNC_POL != 0);

    logic [CNT_W-1:0] hc_q, hc_d, vc_q, vc_d;
    logic [1:0]       mode_q, mode_d;

    logic             hsync_q, hsync_d, vsync_q, vsync_d;
    logic [RW-1:0]    red_q, red_d;
    logic [GW-1:0]    green_q, green_d;
    logic [BW-1:0]    blue_q, blue_d;
    logic             de_q, de_d, fs_q, fs_d;
    logic [CNT_W-1:0] px_q, px_d, py_q, py_d;

    logic             act;
    logic [CNT_W-1:0] px_c, py_c, bar_c;
    logic [2:0]       bar_idx;
    logic [2:0]       rgb;  // on/off per channel: {r, g, b}

    // Counters; mode is only latched on the last pixel of a frame to avoid tearing
    always_comb begin
        hc_d   = hc_q;
        vc_d   = vc_q;
        mode_d = mode_q;
        if (en) begin
            if (hc_q == H_LAST) begin
                hc_d = '0;
                if (vc_q == V_LAST) begin
                    vc_d   = '0;
                    mode_d = mode;
                end else begin
                    vc_d = vc_q + CNT_W'(1);
                end
            end else begin
                hc_d = hc_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        act     = (hc_q >= H_ACT_BEG) && (hc_q < H_ACT_END) &&
                  (vc_q >= V_ACT_BEG) && (vc_q < V_ACT_END);
        px_c    = act ? (hc_q - H_ACT_BEG) : '0;
        py_c    = act ? (vc_q - V_ACT_BEG) : '0;
        bar_c   = px_c / BAR_W;
        bar_idx = (bar_c > CNT_W'(7)) ? 3'd7 : bar_c[2:0];
        rgb     = 3'b000;
        if (act) begin
            unique case (mode_q)
                2'd0: begin
                    unique case (bar_idx)
                        3'd0:    rgb = 3'b111;
                        3'd1:    rgb = 3'b110;
                        3'd2:    rgb = 3'b011;
                        3'd3:    rgb = 3'b010;
                        3'd4:    rgb = 3'b101;
                        3'd5:    rgb = 3'b100;
                        3'd6:    rgb = 3'b001;
                        default: rgb = 3'b000;
                    endcase
                end
                2'd1: rgb = (px_c[5] ^ py_c[5]) ? 3'b000 : 3'b111;
                2'd2: rgb = ((px_c[4:0] == 5'd0) || (py_c[4:0] == 5'd0) ||
                             (px_c == H_ACT_LAST) || (py_c == V_ACT_LAST)) ? 3'b111 : 3'b000;
                default: rgb = 3'b001;
            endcase
        end
    end

    always_comb begin
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        red_d   = red_q;
        green_d = green_q;
        blue_d  = blue_q;
        de_d    = de_q;
        px_d    = px_q;
        py_d    = py_q;
        fs_d    = 1'b0;
        if (en) begin
            hsync_d = (hc_q < H_SYNC_END) ? HS_ON : ~HS_ON;
            vsync_d = (vc_q < V_SYNC_END) ? VS_ON : ~VS_ON;
            red_d   = {RW{rgb[2]}};
            green_d = {GW{rgb[1]}};
            blue_d  = {BW{rgb[0]}};
            de_d    = act;
            px_d    = px_c;
            py_d    = py_c;
            fs_d    = (hc_q == '0) && (vc_q == '0);
        end
    end

    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            hc_q    <= '0;
            vc_q    <= '0;
            mode_q  <= '0;
            hsync_q <= ~HS_ON;
            vsync_q <= ~VS_ON;
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
            de_q    <= 1'b0;
            px_q    <= '0;
            py_q    <= '0;
            fs_q    <= 1'b0;
        end else begin
            hc_q    <= hc_d;
            vc_q    <= vc_d;
            mode_q  <= mode_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
            de_q    <= de_d;
            px_q    <= px_d;
            py_q    <= py_d;
            fs_q    <= fs_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign red         = red_q;
    assign green       = green_q;
    assign blue        = blue_q;
    assign de          = de_q;
    assign px          = px_q;
    assign py          = py_q;
    assign frame_start = fs_q;

endmodule
